// File: rtl/nerf_pkg.sv
`default_nettype none
// ============================================================================
// Package  : nerf_pkg
// Brief    : Shared types, constants and helpers for the spike counting blocks.
// Revision : 1.0
// ============================================================================
package nerf_pkg;

    typedef enum logic {
        MODE_WINDOWED   = 1'b0,
        MODE_CUMULATIVE = 1'b1
    } count_mode_e;

    localparam int COUNT_W = 32;

    // Width of a channel selector; a single channel still gets one select bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Saturating increment of a width-bit value held in a COUNT_W container.
    // Result is {next_value, overflow}: the flag sits in the LSB so a caller
    // can keep exactly its own width+1 bits with a truncating cast.
    function automatic logic [COUNT_W:0] sat_inc(
        input logic [COUNT_W-1:0] val,
        input logic               inc,
        input logic [5:0]         width
    );
        logic [COUNT_W:0] sum;
        sum = {1'b0, val} + {{COUNT_W{1'b0}}, inc};
        if (sum[width]) begin
            return {val, 1'b1};
        end
        return {sum[COUNT_W-1:0], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spike_counter_array_if.sv
`default_nettype none
// ============================================================================
// Interface : spike_counter_array_if
// Brief     : Spike inputs, control and readout bundle of spike_counter_array.
// Revision  : 1.0
// ============================================================================
interface spike_counter_array_if #(
    parameter int NCH = 8,
    parameter int W   = nerf_pkg::COUNT_W
);
    localparam int SELW = nerf_pkg::sel_width(NCH);

    logic [NCH-1:0]   spike_in;
    logic             mode;
    logic             clear;
    logic [SELW-1:0]  rd_sel;
    logic [NCH*W-1:0] counts_flat;
    logic [W-1:0]     rd_count;
    logic [NCH-1:0]   sat_flags;
    logic             window_valid;

    modport master (
        output spike_in,
        output mode,
        output clear,
        output rd_sel,
        input  counts_flat,
        input  rd_count,
        input  sat_flags,
        input  window_valid
    );

    modport slave (
        input  spike_in,
        input  mode,
        input  clear,
        input  rd_sel,
        output counts_flat,
        output rd_count,
        output sat_flags,
        output window_valid
    );

endinterface
`default_nettype wire

// File: rtl/spike_count_channel.sv
`default_nettype none
// ============================================================================
// Module   : spike_count_channel
// Brief    : One channel: rising-edge spike detect, saturating accumulator,
//            sticky saturation flag and the per-window latched count.
// Revision : 1.0
// ============================================================================
module spike_count_channel
    import nerf_pkg::*;
#(
    parameter int W = COUNT_W
) (
    input  wire logic         clk,
    input  wire logic         reset_global,
    input  wire logic         spike,
    input  wire logic         win_end,
    input  wire logic         clear,
    input  wire logic         mode_r,
    output logic [W-1:0]      count,
    output logic              sat_flag
);

    logic         r_prev;
    logic [W-1:0] r_acc;
    logic         r_sat_acc;
    logic [W-1:0] r_count;
    logic         r_sat_flag;

    logic         w_hit;
    logic [W-1:0] w_acc_inc;
    logic         w_sat_inc;
    logic         w_sat_any;

    assign w_hit = spike & ~r_prev;
    assign {w_acc_inc, w_sat_inc} = (W+1)'(sat_inc(COUNT_W'(r_acc), w_hit, 6'(W)));
    assign w_sat_any = r_sat_acc | w_sat_inc;

    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= spike;
        end
    end

    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            r_acc      <= '0;
            r_sat_acc  <= 1'b0;
            r_count    <= '0;
            r_sat_flag <= 1'b0;
        end else if (clear) begin
            r_acc      <= '0;
            r_sat_acc  <= 1'b0;
            r_count    <= '0;
            r_sat_flag <= 1'b0;
        end else if (win_end) begin
            if (mode_r == MODE_WINDOWED) begin
                // A hit on the boundary cycle opens the new window.
                r_count    <= r_acc;
                r_sat_flag <= r_sat_acc;
                r_acc      <= W'(w_hit);
                r_sat_acc  <= 1'b0;
            end else begin
                r_count    <= w_acc_inc;
                r_sat_flag <= w_sat_any;
                r_acc      <= w_acc_inc;
                r_sat_acc  <= w_sat_any;
            end
        end else begin
            r_acc     <= w_acc_inc;
            r_sat_acc <= w_sat_any;
        end
    end

    assign count    = r_count;
    assign sat_flag = r_sat_flag;

endmodule
`default_nettype wire

// File: rtl/spike_counter_array.sv
`default_nettype none
// ============================================================================
// Module   : spike_counter_array
// Brief    : NCH-channel spike counter latched on each sim_clk rising edge,
//            with windowed/cumulative modes, saturation flags and a read port.
// Revision : 1.0
// ============================================================================
module spike_counter_array
    import nerf_pkg::*;
#(
    parameter int NCH         = 8,
    parameter int W           = COUNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic            clk,
    input  wire logic            reset_global,
    input  wire logic            sim_clk,
    spike_counter_array_if.slave bus
);

    localparam int SELW   = sel_width(NCH);
    localparam int c_nsel = 1 << SELW;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_win_end;
    logic                   w_latch;
    count_mode_e            r_mode;
    logic                   r_window_valid;
    logic [W-1:0]           r_rd_count;
    logic [W-1:0]           w_count [c_nsel];
    logic [NCH-1:0]         w_sat;

    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sim_clk};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_win_end = r_sync[SYNC_STAGES-1] & ~r_hist;
    // A clear on the boundary cycle discards that boundary entirely.
    assign w_latch   = w_win_end & ~bus.clear;

    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            r_mode         <= MODE_WINDOWED;
            r_window_valid <= 1'b0;
        end else begin
            r_window_valid <= w_latch;
            if (w_latch) begin
                r_mode <= count_mode_e'(bus.mode);
            end
        end
    end

    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            r_rd_count <= '0;
        end else begin
            r_rd_count <= w_count[bus.rd_sel];
        end
    end

    // Select codes past the last channel read back as zero.
    generate
        for (genvar i = 0; i < c_nsel; i++) begin : g_chan
            if (i < NCH) begin : g_live
                spike_count_channel #(
                    .W(W)
                ) u_chan (
                    .clk          (clk),
                    .reset_global (reset_global),
                    .spike        (bus.spike_in[i]),
                    .win_end      (w_win_end),
                    .clear        (bus.clear),
                    .mode_r       (r_mode),
                    .count        (w_count[i]),
                    .sat_flag     (w_sat[i])
                );
                assign bus.counts_flat[i*W +: W] = w_count[i];
            end else begin : g_pad
                assign w_count[i] = '0;
            end
        end
    endgenerate

    assign bus.sat_flags    = w_sat;
    assign bus.rd_count     = r_rd_count;
    assign bus.window_valid = r_window_valid;

endmodule
`default_nettype wire

// File: tb/tb_spike_counter_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_counter_array
// Brief    : Randomised self-checking bench against a window-count model.
// Revision : 1.0
// ============================================================================
module tb_spike_counter_array;

    localparam int NCH         = 6;
    localparam int W           = 8;
    localparam int SYNC_STAGES = 2;
    localparam int SELW        = 3;
    localparam int MAXC        = (1 << W) - 1;

    logic clk = 1'b0;
    logic reset_global;
    logic sim_clk;

    spike_counter_array_if #(.NCH(NCH), .W(W)) bus ();

    spike_counter_array #(
        .NCH         (NCH),
        .W           (W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .reset_global (reset_global),
        .sim_clk      (sim_clk),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: hits since window start (windowed) or since clear (cumulative).
    int             m_acc [NCH];
    int             m_cnt [NCH];
    bit             m_sat [NCH];
    bit             m_mode;
    logic [NCH-1:0] drv_prev;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int a);
        return (a > MAXC) ? MAXC : a;
    endfunction

    function automatic logic [63:0] exp_flat();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) v[i*W +: W] = W'(m_cnt[i]);
        return v;
    endfunction

    function automatic logic [63:0] exp_sat();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) v[i] = m_sat[i];
        return v;
    endfunction

    function automatic int exp_rd(input int sel);
        return (sel < NCH) ? m_cnt[sel] : 0;
    endfunction

    task automatic model_zero();
        for (int i = 0; i < NCH; i++) begin
            m_acc[i] = 0;
            m_cnt[i] = 0;
            m_sat[i] = 1'b0;
        end
    endtask

    task automatic drive(input logic [NCH-1:0] v);
        @(negedge clk);
        for (int i = 0; i < NCH; i++) if (v[i] && !drv_prev[i]) m_acc[i]++;
        drv_prev     = v;
        bus.spike_in = v;
    endtask

    task automatic pulses(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            drive(NCH'(1) << ch);
            drive('0);
        end
    endtask

    task automatic hold(input int ch, input int cycles);
        for (int k = 0; k < cycles; k++) drive(NCH'(1) << ch);
        drive('0);
    endtask

    task automatic random_window(input int ncyc, input int pct);
        logic [NCH-1:0] v;
        for (int k = 0; k < ncyc; k++) begin
            for (int i = 0; i < NCH; i++) v[i] = ($urandom_range(0, 99) < pct);
            drive(v);
        end
        drive('0);
    endtask

    // Raise sim_clk, optionally spike or clear on the boundary cycle, then check.
    task automatic boundary(input logic [NCH-1:0] coinc, input bit with_clear, input string tag);
        int lat   = 0;
        int highs = 0;
        drive('0);
        @(negedge clk);
        sim_clk = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            #1;
            if (bus.window_valid === 1'b1) begin
                highs++;
                if (lat == 0) lat = c;
            end
            @(negedge clk);
            if (c == 2) begin
                bus.spike_in = coinc;
                drv_prev     = coinc;
                bus.clear    = with_clear;
            end else if (c == 3) begin
                bus.spike_in = '0;
                drv_prev     = '0;
                bus.clear    = 1'b0;
            end
        end
        sim_clk = 1'b0;
        repeat (4) @(negedge clk);

        if (with_clear) begin
            check_val($sformatf("%s_no_valid", tag), 64'(highs), 64'd0);
            model_zero();
        end else begin
            check_val($sformatf("%s_latency", tag), 64'(lat), 64'(SYNC_STAGES + 1));
            check_val($sformatf("%s_valid_width", tag), 64'(highs), 64'd1);
            for (int i = 0; i < NCH; i++) begin
                if (!m_mode) begin
                    m_cnt[i] = clamp(m_acc[i]);
                    m_sat[i] = (m_acc[i] > MAXC);
                    m_acc[i] = int'(coinc[i]);
                end else begin
                    m_acc[i] += int'(coinc[i]);
                    m_cnt[i] = clamp(m_acc[i]);
                    m_sat[i] = (m_acc[i] > MAXC);
                end
            end
            m_mode = bus.mode;
        end
        check_val($sformatf("%s_counts", tag), 64'(bus.counts_flat), exp_flat());
        check_val($sformatf("%s_sat", tag), 64'(bus.sat_flags), exp_sat());
        check_val($sformatf("%s_rd_follow", tag), 64'(bus.rd_count), 64'(exp_rd(int'(bus.rd_sel))));
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        model_zero();
        check_val("clear_counts", 64'(bus.counts_flat), 64'd0);
        check_val("clear_sat", 64'(bus.sat_flags), 64'd0);
    endtask

    task automatic check_rd(input int sel);
        @(negedge clk);
        bus.rd_sel = SELW'(sel);
        @(posedge clk);
        #1;
        check_val($sformatf("rd_count_sel%0d", sel), 64'(bus.rd_count), 64'(exp_rd(sel)));
    endtask

    task automatic check_all_zero(input string tag);
        check_val($sformatf("%s_counts", tag), 64'(bus.counts_flat), 64'd0);
        check_val($sformatf("%s_sat", tag), 64'(bus.sat_flags), 64'd0);
        check_val($sformatf("%s_rd", tag), 64'(bus.rd_count), 64'd0);
        check_val($sformatf("%s_valid", tag), 64'(bus.window_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_global = 1'b1;
        sim_clk      = 1'b0;
        bus.spike_in = '0;
        bus.mode     = 1'b0;
        bus.clear    = 1'b0;
        bus.rd_sel   = '0;
        drv_prev     = '0;
        m_mode       = 1'b0;
        model_zero();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_global = 1'b0;
        repeat (2) @(negedge clk);

        // Windowed: isolated pulses on channel 3, then an empty step.
        bus.rd_sel = SELW'(3);
        pulses(3, 5);
        boundary('0, 1'b0, "win5");
        boundary('0, 1'b0, "win_empty");

        // Boundary collision and a held spike.
        pulses(5, 2);
        hold(4, 10);
        boundary(NCH'(1) << 5, 1'b0, "collide");
        for (int s = 0; s < 8; s++) check_rd(s);
        boundary('0, 1'b0, "collide_next");

        for (int r = 0; r < 4; r++) begin
            random_window($urandom_range(30, 80), $urandom_range(10, 60));
            boundary(NCH'($urandom), 1'b0, $sformatf("rwin%0d", r));
        end

        // Mode change mid-step takes effect one boundary later.
        bus.rd_sel = SELW'(2);
        pulses(2, 2);
        bus.mode = 1'b1;
        pulses(2, 2);
        boundary('0, 1'b0, "cum0");
        pulses(2, 4);
        boundary('0, 1'b0, "cum1");
        pulses(2, 4);
        boundary('0, 1'b0, "cum2");
        for (int r = 0; r < 8; r++) begin
            random_window(150, 50);
            boundary(NCH'($urandom), 1'b0, $sformatf("cumr%0d", r));
        end
        bus.mode = 1'b0;
        random_window(20, 30);
        boundary('0, 1'b0, "cum_exit");
        clear_pulse();

        // Windowed saturation, then recovery.
        bus.rd_sel = SELW'(1);
        pulses(1, 300);
        boundary('0, 1'b0, "sat300");
        pulses(1, 2);
        boundary('0, 1'b0, "sat_recover");

        // Clear on the boundary cycle wins.
        bus.rd_sel = SELW'(2);
        pulses(2, 7);
        boundary('0, 1'b1, "clr_boundary");
        pulses(2, 3);
        boundary('0, 1'b0, "after_clr");

        // Asynchronous reset mid-step.
        pulses(0, 4);
        @(negedge clk);
        #2;
        reset_global = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset_global = 1'b0;
        m_mode       = 1'b0;
        drv_prev     = '0;
        model_zero();
        pulses(0, 2);
        boundary('0, 1'b0, "post_reset");
        check_rd(0);
        check_rd(6);
        check_rd(7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
